// File: rtl/mz_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mz_rom_arbiter : round-robin sharing of the boot/monitor ROM between the   |
// |                  Z80 fetch path (port 0) and the ROM loader (port 1).      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mz_rom_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_valid,
  output logic          cpu_wait_n,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_valid,
  output logic [DW-1:0] rdata,
  output logic [1:0]    ovr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  logic          r_cpu_pend;
  logic          r_ld_pend;
  logic [AW-1:0] r_cpu_addr;
  logic [AW-1:0] r_ld_addr;
  logic          r_last_grant;
  logic          r_s1_v;
  logic          r_s1_own;
  logic          r_s2_v;
  logic          r_s2_own;

  logic          w_cpu_busy;
  logic          w_ld_busy;
  logic          w_cpu_acc;
  logic          w_ld_acc;
  logic          w_cpu_cand;
  logic          w_ld_cand;
  logic          w_issue;
  logic          w_grant_ld;
  logic [AW-1:0] w_cpu_sel;
  logic [AW-1:0] w_ld_sel;

  // A requester is busy while it waits in the pending slot or owns either stage.
  always_comb begin
    w_cpu_busy = r_cpu_pend | (r_s1_v & ~r_s1_own) | (r_s2_v & ~r_s2_own);
    w_ld_busy  = r_ld_pend  | (r_s1_v &  r_s1_own) | (r_s2_v &  r_s2_own);
    w_cpu_acc  = cpu_req & ~w_cpu_busy;
    w_ld_acc   = ld_req  & ~w_ld_busy;
    w_cpu_cand = w_cpu_acc | r_cpu_pend;
    w_ld_cand  = w_ld_acc  | r_ld_pend;
    w_issue    = w_cpu_cand | w_ld_cand;
    // On contention the port that did not win last time goes first.
    w_grant_ld = w_ld_cand & (~w_cpu_cand | ~r_last_grant);
    w_cpu_sel  = r_cpu_pend ? r_cpu_addr : cpu_addr;
    w_ld_sel   = r_ld_pend  ? r_ld_addr  : ld_addr;
  end

  assign cpu_wait_n = ~w_cpu_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_pend   <= 1'b0;
      r_ld_pend    <= 1'b0;
      r_cpu_addr   <= '0;
      r_ld_addr    <= '0;
      r_last_grant <= 1'b1;
      r_s1_v       <= 1'b0;
      r_s1_own     <= 1'b0;
      r_s2_v       <= 1'b0;
      r_s2_own     <= 1'b0;
      rom_addr     <= '0;
      rdata        <= '0;
      cpu_valid    <= 1'b0;
      ld_valid     <= 1'b0;
      ovr          <= 2'b00;
    end else begin
      if (w_cpu_acc) r_cpu_addr <= cpu_addr;
      if (w_ld_acc)  r_ld_addr  <= ld_addr;
      r_cpu_pend <= w_cpu_cand & w_grant_ld;
      r_ld_pend  <= w_ld_cand & ~w_grant_ld;

      if (cpu_req & ~w_cpu_acc) ovr[0] <= 1'b1;
      if (ld_req  & ~w_ld_acc)  ovr[1] <= 1'b1;

      if (w_issue) begin
        rom_addr     <= w_grant_ld ? w_ld_sel : w_cpu_sel;
        r_last_grant <= w_grant_ld;
      end
      r_s1_v   <= w_issue;
      r_s1_own <= w_grant_ld;
      r_s2_v   <= r_s1_v;
      r_s2_own <= r_s1_own;

      // rom_data now reflects the address that was in stage1 last cycle.
      if (r_s2_v) rdata <= rom_data;
      cpu_valid <= r_s2_v & ~r_s2_own;
      ld_valid  <= r_s2_v &  r_s2_own;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mz_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mz_rom_arbiter : vector-table and directed checks for mz_rom_arbiter.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mz_rom_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic        cpu_valid;
  logic        cpu_wait_n;
  logic        ld_req;
  logic [10:0] ld_addr;
  logic        ld_valid;
  logic [7:0]  rdata;
  logic [1:0]  ovr;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  int n_chk;
  int n_err;

  typedef struct {
    logic        cr;
    logic [10:0] ca;
    logic        lr;
    logic [10:0] la;
    logic        cv;
    logic        lv;
    logic [7:0]  rd;
    logic        wn;
    logic [1:0]  ov;
    logic [10:0] ra;
  } vec_t;

  vec_t tbl[$];

  mz_rom_arbiter #(.AW(11), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_valid (cpu_valid),
    .cpu_wait_n(cpu_wait_n),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_valid  (ld_valid),
    .rdata     (rdata),
    .ovr       (ovr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: first bytes of the monitor image, a filler pattern elsewhere.
  logic [7:0] rom_img [0:15];
  initial begin
    rom_img[0]  = 8'h21; rom_img[1]  = 8'h00; rom_img[2]  = 8'hd0; rom_img[3]  = 8'h3e;
    rom_img[4]  = 8'h00; rom_img[5]  = 8'h77; rom_img[6]  = 8'h23; rom_img[7]  = 8'h3c;
    rom_img[8]  = 8'h18; rom_img[9]  = 8'hfb; rom_img[10] = 8'hc3; rom_img[11] = 8'h00;
    rom_img[12] = 8'h01; rom_img[13] = 8'h02; rom_img[14] = 8'h03; rom_img[15] = 8'h04;
  end
  always @(posedge clk)
    rom_data <= (rom_addr < 11'd16) ? rom_img[rom_addr[3:0]] : (rom_addr[7:0] ^ 8'h5a);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, ".rdata"},    32'(rdata),    32'h0);
    chk({tag, ".cv"},       32'(cpu_valid), 32'h0);
    chk({tag, ".lv"},       32'(ld_valid),  32'h0);
    chk({tag, ".wn"},       32'(cpu_wait_n), 32'h1);
    chk({tag, ".ovr"},      32'(ovr),       32'h0);
  endtask

  // Enter just after a rising edge; leave one edge later, #1 past it.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input logic cr, input logic [10:0] ca, input logic lr, input logic [10:0] la);
    cpu_req = cr; cpu_addr = ca; ld_req = lr; ld_addr = la;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; ld_req = 1'b0;
  endtask

  function automatic vec_t mk(input logic cr, input logic [10:0] ca, input logic cv,
                              input logic [7:0] rd, input logic wn, input logic [10:0] ra);
    vec_t v;
    v.cr = cr; v.ca = ca; v.lr = 1'b0; v.la = '0;
    v.cv = cv; v.lv = 1'b0; v.rd = rd; v.wn = wn; v.ov = 2'b00; v.ra = ra;
    return v;
  endfunction

  initial begin
    logic [7:0] seq [0:9];
    int npulse;
    n_chk = 0; n_err = 0;
    reset = 1'b1; cpu_req = 1'b0; ld_req = 1'b0; cpu_addr = '0; ld_addr = '0;
    seq[0] = 8'h21; seq[1] = 8'h00; seq[2] = 8'hd0; seq[3] = 8'h3e; seq[4] = 8'h00;
    seq[5] = 8'h77; seq[6] = 8'h23; seq[7] = 8'h3c; seq[8] = 8'h18; seq[9] = 8'hfb;

    // Single CPU fetch of 000, then 001..009 each requested in the previous valid cycle.
    tbl.push_back(mk(1'b1, 11'h000, 1'b0, 8'h00, 1'b0, 11'h000));
    tbl.push_back(mk(1'b0, 11'h000, 1'b0, 8'h00, 1'b0, 11'h000));
    tbl.push_back(mk(1'b0, 11'h000, 1'b1, 8'h21, 1'b1, 11'h000));
    tbl.push_back(mk(1'b0, 11'h000, 1'b0, 8'h21, 1'b1, 11'h000));
    for (int a = 1; a <= 9; a++) begin
      tbl.push_back(mk(1'b1, 11'(a), 1'b0, seq[a-1], 1'b0, 11'(a)));
      tbl.push_back(mk(1'b0, 11'h000, 1'b0, seq[a-1], 1'b0, 11'(a)));
      tbl.push_back(mk(1'b0, 11'h000, 1'b1, seq[a],   1'b1, 11'(a)));
    end

    @(posedge clk);
    #1;
    do_reset("rst0");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cr, tbl[i].ca, tbl[i].lr, tbl[i].la);
      chk($sformatf("vec%0d.cv", i), 32'(cpu_valid), 32'(tbl[i].cv));
      chk($sformatf("vec%0d.lv", i), 32'(ld_valid),  32'(tbl[i].lv));
      chk($sformatf("vec%0d.rd", i), 32'(rdata),     32'(tbl[i].rd));
      chk($sformatf("vec%0d.wn", i), 32'(cpu_wait_n), 32'(tbl[i].wn));
      chk($sformatf("vec%0d.ov", i), 32'(ovr),       32'(tbl[i].ov));
      chk($sformatf("vec%0d.ra", i), 32'(rom_addr),  32'(tbl[i].ra));
    end

    // Contention right after reset: CPU first, loader one cycle later.
    do_reset("rst1");
    step(1'b1, 11'h002, 1'b1, 11'h008);
    chk("ct0.ra", 32'(rom_addr), 32'h002);
    chk("ct0.wn", 32'(cpu_wait_n), 32'h0);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct1.ra", 32'(rom_addr), 32'h008);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct2.cv", 32'(cpu_valid), 32'h1);
    chk("ct2.lv", 32'(ld_valid), 32'h0);
    chk("ct2.rd", 32'(rdata), 32'hd0);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct3.lv", 32'(ld_valid), 32'h1);
    chk("ct3.cv", 32'(cpu_valid), 32'h0);
    chk("ct3.rd", 32'(rdata), 32'h18);
    // A lone CPU access makes the CPU the last grantee, so the loader wins next.
    step(1'b1, 11'h001, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct6.cv", 32'(cpu_valid), 32'h1);
    chk("ct6.rd", 32'(rdata), 32'h00);
    step(1'b1, 11'h003, 1'b1, 11'h009);
    chk("ct7.ra", 32'(rom_addr), 32'h009);
    chk("ct7.wn", 32'(cpu_wait_n), 32'h0);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct8.ra", 32'(rom_addr), 32'h003);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct9.lv", 32'(ld_valid), 32'h1);
    chk("ct9.rd", 32'(rdata), 32'hfb);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("ct10.cv", 32'(cpu_valid), 32'h1);
    chk("ct10.rd", 32'(rdata), 32'h3e);
    chk("ct10.ovr", 32'(ovr), 32'h0);

    // Second CPU request while the first is in flight is dropped and flagged.
    step(1'b1, 11'h004, 1'b0, 11'h000);
    step(1'b1, 11'h005, 1'b0, 11'h000);
    chk("ov1.ovr", 32'(ovr), 32'h1);
    chk("ov1.ra", 32'(rom_addr), 32'h004);
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 11'h000, 1'b0, 11'h000);
      if (cpu_valid) npulse++;
      if (k == 0) chk("ov2.rd_early", 32'(cpu_valid), 32'h1);
    end
    chk("ov.pulses", 32'(npulse), 32'h1);
    chk("ov.rd", 32'(rdata), 32'h00);
    chk("ov.sticky", 32'(ovr), 32'h1);

    // Reset while a loader access sits in stage2.
    do_reset("rst2");
    step(1'b0, 11'h000, 1'b1, 11'h007);
    chk("rm0.wn", 32'(cpu_wait_n), 32'h1);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rm_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 11'h000, 1'b0, 11'h000);
      if (ld_valid) npulse++;
    end
    chk("rm.no_lv", 32'(npulse), 32'h0);
    chk("rm.rd", 32'(rdata), 32'h00);
    step(1'b0, 11'h000, 1'b1, 11'h006);
    chk("rm.ra", 32'(rom_addr), 32'h006);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    step(1'b0, 11'h000, 1'b0, 11'h000);
    chk("rm.lv", 32'(ld_valid), 32'h1);
    chk("rm.cv", 32'(cpu_valid), 32'h0);
    chk("rm.rd2", 32'(rdata), 32'h23);
    chk("rm.ovr", 32'(ovr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
